// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory access unit.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD     = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WR     = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wide enough for any ACK_TIMEOUT in 1..255
    localparam int ACK_CNT_W = 8;

    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_lane_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_lane_unit
// Description : Little-endian lane extract/extend for loads and lane merge
//               for read-modify-write stores. Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_byte_sign;
    logic        w_half_sign;

    always_comb begin
        w_byte      = rdata[{addr_lo, 3'b000} +: 8];
        w_half      = rdata[{addr_lo[1], 4'b0000} +: 16];
        w_byte_sign = ~is_unsigned & w_byte[7];
        w_half_sign = ~is_unsigned & w_half[15];

        case (size)
            SZ_BYTE: load_data = {{24{w_byte_sign}}, w_byte};
            SZ_HALF: load_data = {{16{w_half_sign}}, w_half};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        merged_word = rdata;
        case (size)
            SZ_BYTE: merged_word[{addr_lo, 3'b000} +: 8]     = store_data[7:0];
            SZ_HALF: merged_word[{addr_lo[1], 4'b0000} +: 16] = store_data[15:0];
            default: merged_word = store_data;
        endcase
    end

endmodule : dmem_lane_unit
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : MEM-stage load/store unit. Turns byte/half/word accesses into
//               word transfers on a req/ack memory port, with RMW for
//               sub-word stores, misalignment and ack-timeout errors.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
)(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i
);

    localparam logic [ACK_CNT_W-1:0] c_to_limit = ACK_CNT_W'(ACK_TIMEOUT - 1);

    state_t                 r_state;
    logic [ACK_CNT_W-1:0]   r_to_cnt;
    logic [31:0]            r_data;
    logic                   r_done;
    logic                   r_err;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_wdata;

    logic                   w_op;
    logic                   w_misaligned;
    logic                   w_word_size;
    logic                   w_timeout;
    logic                   w_busy;
    logic [31:0]            w_load_data;
    logic [31:0]            w_merged_word;

    // MemWrite_i takes priority, so a load is an op with MemWrite_i low
    assign w_op         = req_i & (MemRead_i | MemWrite_i);
    assign w_misaligned = is_misaligned(size_i, addr_i[1:0]);
    assign w_word_size  = size_i[1];
    assign w_timeout    = (r_to_cnt == c_to_limit);
    assign w_busy       = (r_state == ST_RD) | (r_state == ST_RMW_RD) | (r_state == ST_WR);

    dmem_lane_unit u_lane (
        .rdata       (mem_rdata_i),
        .addr_lo     (addr_i[1:0]),
        .size        (size_i),
        .is_unsigned (unsigned_i),
        .store_data  (data_i),
        .load_data   (w_load_data),
        .merged_word (w_merged_word)
    );

    assign stall_o     = ((r_state == ST_IDLE) & w_op & ~w_misaligned) | w_busy;
    assign data_o      = r_data;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_to_cnt    <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (w_op) begin
                        if (w_misaligned) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= {addr_i[31:2], 2'b00};
                            if (!MemWrite_i) begin
                                r_state  <= ST_RD;
                                r_mem_we <= 1'b0;
                            end else if (w_word_size) begin
                                r_state     <= ST_WR;
                                r_mem_we    <= 1'b1;
                                r_mem_wdata <= data_i;
                            end else begin
                                r_state  <= ST_RMW_RD;
                                r_mem_we <= 1'b0;
                            end
                        end
                    end
                end

                ST_RD: begin
                    if (mem_ack_i) begin
                        r_data    <= w_load_data;
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_to_cnt  <= '0;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt  <= r_to_cnt + 1'b1;
                    end
                end

                // Request stays high into WR so the write follows back-to-back
                ST_RMW_RD: begin
                    if (mem_ack_i) begin
                        r_mem_wdata <= w_merged_word;
                        r_mem_we    <= 1'b1;
                        r_state     <= ST_WR;
                        r_to_cnt    <= '0;
                    end else if (w_timeout) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_err     <= 1'b1;
                        r_mem_req <= 1'b0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt  <= r_to_cnt + 1'b1;
                    end
                end

                ST_WR: begin
                    if (mem_ack_i || w_timeout) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_err     <= ~mem_ack_i;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt  <= r_to_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state  <= ST_IDLE;
                    r_to_cnt <= '0;
                end

                default: begin
                    r_state   <= ST_IDLE;
                    r_to_cnt  <= '0;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

endmodule : dmem_access_unit
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Directed self-checking bench with a transaction-level model
//               and a behavioural word memory with programmable ack latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0, unsigned_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic [31:0] addr_i = '0, data_i = '0;
    logic [31:0] data_o, mem_addr_o, mem_wdata_o;
    logic        stall_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;

    always #5 clk = ~clk;

    dmem_access_unit #(.ACK_TIMEOUT(T)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .MemRead_i(MemRead_i),
        .MemWrite_i(MemWrite_i), .size_i(size_i), .unsigned_i(unsigned_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
        .done_o(done_o), .err_o(err_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem     [0:63];
    logic [31:0] exp_mem [0:63];
    int lat  = 0;
    int wcnt = 0;

    bit  active = 0, quiet_chk = 0;
    int  op_id = 0, seen_id = 0, cyc = 0;
    bit  e_mis, e_err, e_write, e_word, req_exp, we_exp;
    int  e_req_cycles, e_phase1, e_done_cyc;
    logic [31:0] e_addr, e_data_o, e_wword, prev_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] w, input int a, input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (w >> (16 * (a / 2))) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d, input int a, input int sz);
        logic [31:0] m;
        if (sz == 0)      m = 32'hFF << (8 * a);
        else if (sz == 1) m = 32'hFFFF << (16 * (a / 2));
        else              m = 32'hFFFF_FFFF;
        return (old & ~m) | ((d << (sz == 0 ? 8 * a : (sz == 1 ? 16 * (a / 2) : 0))) & m);
    endfunction

    // Word memory: acks after `lat` waiting cycles of a held request
    always @(negedge clk) begin
        if (mem_ack_i) wcnt = 0;
        if (mem_req_o) begin
            if (wcnt == lat) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = mem[mem_addr_o[7:2]];
                if (mem_we_o) mem[mem_addr_o[7:2]] = mem_wdata_o;
            end else begin
                mem_ack_i   = 1'b0;
                mem_rdata_i = 32'hDEAD_BEEF;
                wcnt++;
            end
        end else begin
            mem_ack_i   = 1'b0;
            mem_rdata_i = 32'hDEAD_BEEF;
            wcnt        = 0;
        end
    end

    // Cycle-by-cycle comparison against the current op's expectation
    always @(negedge clk) begin
        if (active) begin
            if (op_id != seen_id) begin
                seen_id = op_id;
                cyc     = 1;
            end else begin
                cyc++;
            end
            check($sformatf("op%0d stall c%0d", op_id, cyc), {31'b0, stall_o}, {31'b0, (!e_mis && cyc < e_done_cyc)});
            check($sformatf("op%0d done c%0d", op_id, cyc), {31'b0, done_o}, {31'b0, (cyc == e_done_cyc)});
            check($sformatf("op%0d err c%0d", op_id, cyc), {31'b0, err_o}, {31'b0, (cyc == e_done_cyc && e_err)});
            req_exp = (cyc >= 2) && (cyc <= 1 + e_req_cycles);
            check($sformatf("op%0d mem_req c%0d", op_id, cyc), {31'b0, mem_req_o}, {31'b0, req_exp});
            if (req_exp) begin
                we_exp = e_write && (e_word || cyc > 1 + e_phase1);
                check($sformatf("op%0d mem_we c%0d", op_id, cyc), {31'b0, mem_we_o}, {31'b0, we_exp});
                check($sformatf("op%0d mem_addr c%0d", op_id, cyc), mem_addr_o, e_addr);
                if (we_exp)
                    check($sformatf("op%0d mem_wdata c%0d", op_id, cyc), mem_wdata_o, e_wword);
            end
            if (cyc == e_done_cyc)
                check($sformatf("op%0d data_o", op_id), data_o, e_data_o);
        end else if (quiet_chk) begin
            check("idle quiet", {29'b0, stall_o, done_o, mem_req_o}, 32'd0);
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        exp_mem[idx] = v;
    endtask

    task automatic run_op(input bit rd, input bit wr, input int sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] data, input int l);
        int idx, a;
        bit to;
        @(posedge clk); #1;
        req_i = 1'b1; MemRead_i = rd; MemWrite_i = wr; size_i = sz[1:0];
        unsigned_i = uns; addr_i = addr; data_i = data; lat = l;
        idx = int'(addr[7:2]);
        a   = int'(addr[1:0]);
        e_write = wr;
        e_word  = (sz >= 2);
        e_mis   = (sz == 1 && (a % 2) != 0) || (sz >= 2 && a != 0);
        e_addr  = {addr[31:2], 2'b00};
        if (e_mis) begin
            e_req_cycles = 0; e_phase1 = 0; e_err = 1;
        end else begin
            to       = (l >= T);
            e_phase1 = to ? T : l + 1;
            if (!wr || e_word) e_req_cycles = e_phase1;
            else               e_req_cycles = to ? T : 2 * e_phase1;
            e_err = to;
        end
        e_done_cyc = e_req_cycles + 2;
        e_wword    = e_word ? data : model_store(exp_mem[idx], data, a, sz);
        e_data_o   = (!wr && !e_err) ? model_load(exp_mem[idx], a, sz, uns) : prev_data;
        op_id++;
        active = 1;
        repeat (e_done_cyc) @(negedge clk);
        #1;
        active = 0;
        req_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0;
        prev_data = e_data_o;
        if (wr && !e_err) exp_mem[idx] = e_wword;
        if (wr) check($sformatf("op%0d memory word", op_id), mem[idx], exp_mem[idx]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        prev_data = '0;

        rst_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_o", data_o, 32'd0);
        check("reset mem_addr", mem_addr_o, 32'd0);
        check("reset mem_wdata", mem_wdata_o, 32'd0);
        check("reset ctl", {27'b0, mem_req_o, mem_we_o, done_o, err_o, stall_o}, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        quiet_chk = 1;

        // rd, wr, size, unsigned, addr, data, ack latency
        preload(4, 32'h8899_AABB);
        run_op(1, 0, 2, 0, 32'h10, 32'h0, 0);
        check("lit word load", data_o, 32'h8899_AABB);

        preload(4, 32'h8011_2233);
        run_op(1, 0, 0, 0, 32'h13, 32'h0, 0);
        check("lit signed byte", data_o, 32'hFFFF_FF80);
        run_op(1, 0, 0, 1, 32'h13, 32'h0, 1);
        check("lit unsigned byte", data_o, 32'h0000_0080);
        run_op(1, 0, 1, 0, 32'h12, 32'h0, 0);
        check("lit signed half", data_o, 32'hFFFF_8011);

        preload(8, 32'h1122_3344);
        run_op(0, 1, 0, 0, 32'h21, 32'hFFFF_FFAB, 0);
        check("lit byte store", mem[8], 32'h1122_AB44);

        run_op(1, 0, 2, 0, 32'h06, 32'h0, 0);          // misaligned word load
        run_op(1, 0, 2, 0, 32'h10, 32'h0, 255);        // ack never comes
        check("lit timeout keeps data", data_o, 32'hFFFF_8011);

        run_op(0, 1, 1, 0, 32'h22, 32'h1234_BEEF, 1);
        check("lit half store", mem[8], 32'hBEEF_AB44);
        run_op(1, 0, 2, 0, 32'h20, 32'h0, T - 1);       // ack exactly at the limit
        check("lit ack at limit", data_o, 32'hBEEF_AB44);

        run_op(0, 1, 1, 0, 32'h0B, 32'h5555, 0);        // misaligned half store
        run_op(1, 1, 3, 0, 32'h30, 32'hCAFE_F00D, 2);   // size 11, both set -> word store
        check("lit size3 store", mem[12], 32'hCAFE_F00D);
        run_op(0, 1, 0, 0, 32'h31, 32'h77, 255);        // RMW read times out
        run_op(1, 0, 1, 1, 32'h32, 32'h0, 0);
        check("lit unsigned half", data_o, 32'h0000_CAFE);

        // Reset in the middle of an RMW read
        quiet_chk = 0;
        @(posedge clk); #1;
        req_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b1; size_i = 2'b00;
        addr_i = 32'h21; data_i = 32'h5A; lat = 3;
        @(negedge clk);
        check("rmw pre stall", {31'b0, stall_o}, 32'd1);
        @(negedge clk);
        check("rmw first req", {30'b0, mem_req_o, mem_we_o}, 32'd2);
        @(posedge clk); #1;
        rst_i = 1'b1; req_i = 1'b0; MemWrite_i = 1'b0;
        @(negedge clk);
        check("rmw_rd in progress", {31'b0, mem_req_o}, 32'd1);
        @(negedge clk);
        check("post reset ctl", {27'b0, mem_req_o, mem_we_o, done_o, err_o, stall_o}, 32'd0);
        check("post reset data_o", data_o, 32'd0);
        @(posedge clk); #1;
        rst_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("no done after reset", {30'b0, done_o, mem_req_o}, 32'd0);
        end
        check("aborted store no write", mem[8], exp_mem[8]);
        prev_data = '0;
        quiet_chk = 1;

        run_op(0, 1, 2, 0, 32'h40, 32'h1234_5678, 1);
        check("lit store after reset", mem[16], 32'h1234_5678);
        run_op(1, 0, 2, 0, 32'h40, 32'h0, 0);
        check("lit load after reset", data_o, 32'h1234_5678);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dmem_access_unit
`default_nettype wire
